// File: rtl/serial_bus_arbiter.sv
// Round-robin request/grant arbiter sharing one scl/sda pin pair between two serial masters.
// It adds a guard gap between owners and a hold timeout. Define SERIAL_ARB_STATS_EN to add the grant/timeout statistics counters.
module serial_bus_arbiter #(
  parameter int GUARD_CYCLES = 64,
  parameter int HOLD_TIMEOUT = 27000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       m0_scl_o,
  input  logic       m0_scl_oe,
  input  logic       m0_sda_o,
  input  logic       m0_sda_oe,
  input  logic       m1_scl_o,
  input  logic       m1_scl_oe,
  input  logic       m1_sda_o,
  input  logic       m1_sda_oe,
  output logic       m0_scl_i,
  output logic       m0_sda_i,
  output logic       m1_scl_i,
  output logic       m1_sda_i,
  input  logic       bus_scl_i,
  input  logic       bus_sda_i,
  output logic       bus_scl_o,
  output logic       bus_scl_oe,
  output logic       bus_sda_o,
  output logic       bus_sda_oe,
  output logic       busy,
  output logic [1:0] owner,
  output logic       timeout_pulse
`ifdef SERIAL_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [7:0]  timeout_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam logic [15:0] GUARD_LOAD = 16'(GUARD_CYCLES - 1);
  localparam logic [24:0] HOLD_LAST  = 25'(HOLD_TIMEOUT - 1);
  localparam logic [24:0] HOLD_MAX   = 25'h1FF_FFFF;
  localparam bit          TIMEOUT_EN = (HOLD_TIMEOUT != 32'sd0);

  state_t      state_r;
  logic        last_owner_r;
  logic        lock0_r;
  logic        lock1_r;
  logic [24:0] hold_cnt_r;
  logic [15:0] guard_cnt_r;

  logic elig0_s, elig1_s, take0_s, take1_s, hold_hit_s, to0_s, to1_s;

  assign elig0_s    = req0 & ~lock0_r;
  assign elig1_s    = req1 & ~lock1_r;
  // On a tie the requester that did not own the bus last wins.
  assign take0_s    = (state_r == ST_IDLE) & elig0_s & (~elig1_s | last_owner_r);
  assign take1_s    = (state_r == ST_IDLE) & elig1_s & ~take0_s;
  assign hold_hit_s = TIMEOUT_EN & (hold_cnt_r == HOLD_LAST);
  assign to0_s      = (state_r == ST_OWN0) & req0 & hold_hit_s;
  assign to1_s      = (state_r == ST_OWN1) & req1 & hold_hit_s;

  assign bus_scl_o  = gnt0 ? m0_scl_o  : (gnt1 ? m1_scl_o  : 1'b1);
  assign bus_scl_oe = gnt0 ? m0_scl_oe : (gnt1 ? m1_scl_oe : 1'b0);
  assign bus_sda_o  = gnt0 ? m0_sda_o  : (gnt1 ? m1_sda_o  : 1'b1);
  assign bus_sda_oe = gnt0 ? m0_sda_oe : (gnt1 ? m1_sda_oe : 1'b0);
  assign m0_scl_i   = gnt0 ? bus_scl_i : 1'b1;
  assign m0_sda_i   = gnt0 ? bus_sda_i : 1'b1;
  assign m1_scl_i   = gnt1 ? bus_scl_i : 1'b1;
  assign m1_sda_i   = gnt1 ? bus_sda_i : 1'b1;

  // Arbitration FSM with registered grant/owner/busy/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      owner         <= 2'b00;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      last_owner_r  <= 1'b1;
      lock0_r       <= 1'b0;
      lock1_r       <= 1'b0;
      hold_cnt_r    <= 25'd0;
      guard_cnt_r   <= 16'd0;
    end else begin
      timeout_pulse <= 1'b0;
      if (to0_s)      lock0_r <= 1'b1;
      else if (!req0) lock0_r <= 1'b0;
      if (to1_s)      lock1_r <= 1'b1;
      else if (!req1) lock1_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          hold_cnt_r <= 25'd0;
          if (take0_s) begin
            state_r <= ST_OWN0;
            gnt0    <= 1'b1;
            owner   <= 2'b01;
            busy    <= 1'b1;
          end else if (take1_s) begin
            state_r <= ST_OWN1;
            gnt1    <= 1'b1;
            owner   <= 2'b10;
            busy    <= 1'b1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if ((state_r == ST_OWN0) ? !req0 : !req1) begin
            state_r      <= ST_GUARD;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            owner        <= 2'b00;
            last_owner_r <= (state_r == ST_OWN1);
            guard_cnt_r  <= GUARD_LOAD;
            hold_cnt_r   <= 25'd0;
          end else if (to0_s | to1_s) begin
            state_r       <= ST_GUARD;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            owner         <= 2'b00;
            timeout_pulse <= 1'b1;
            guard_cnt_r   <= GUARD_LOAD;
            hold_cnt_r    <= 25'd0;
          end else if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + 25'd1;
          end
        end
        ST_GUARD: begin
          if (guard_cnt_r == 16'd0) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            guard_cnt_r <= guard_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          owner   <= 2'b00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ARB_STATS_EN
  // Saturating grant and forced-release counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0  <= 16'd0;
      grant_cnt1  <= 16'd0;
      timeout_cnt <= 8'd0;
    end else begin
      if (take0_s && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (take1_s && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      if ((to0_s | to1_s) && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares the single scl_mdc / sda_mdio pin pair between two serial masters:
  - requester 0: MAC MDIO master
  - requester 1: camera SCCB/I2C master
- Replaces the fixed, init-state-based pin mux in the top level with a request/grant arbiter.
- Inserts a bus-released guard interval between owners and force-releases a hung owner after a timeout.
- Sits between the two masters' split in/out/out_en signals and the top-level tristate pin assigns.

Parameters:
- GUARD_CYCLES, 64: clk cycles the bus is released (both oe=0) after an owner drops; range 1..65535.
- HOLD_TIMEOUT, 27000000: maximum clk cycles one grant may last before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 (MAC MDIO) bus request, level.
- req1  in  1  requester 1 (camera SCCB) bus request, level.
- gnt0  out  1  grant to requester 0.
- gnt1  out  1  grant to requester 1.
- m0_scl_o, m0_scl_oe, m0_sda_o, m0_sda_oe  in  1 each  requester 0 pin drive and output enable.
- m1_scl_o, m1_scl_oe, m1_sda_o, m1_sda_oe  in  1 each  requester 1 pin drive and output enable.
- m0_scl_i, m0_sda_i, m1_scl_i, m1_sda_i  out  1 each  pin readback to each requester.
- bus_scl_i, bus_sda_i  in  1 each  pin readback from the tristate pads.
- bus_scl_o, bus_scl_oe, bus_sda_o, bus_sda_oe  out  1 each  to the tristate pads.
- busy  out  1  high whenever state is not IDLE.
- owner  out  2  00 none, 01 requester 0, 10 requester 1.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - gnt0=gnt1=0, owner=00, busy=0, timeout_pulse=0.
  - bus_*_oe=0, bus_*_o=1.
  - last_owner=1, so requester 0 wins the first tie.
  - lock0=lock1=0; guard and hold counters=0.
- States: IDLE, OWN0, OWN1, GUARD.
- IDLE:
  - Eligible requester k means reqk=1 and lockk=0.
  - Only one eligible: go to OWNk; gntk=1 on the next clk edge (1-cycle request-to-grant latency).
  - Both eligible: grant the one that is not last_owner (round-robin).
  - Nothing eligible: stay in IDLE.
- OWNk:
  - bus_scl_o/oe and bus_sda_o/oe combinationally follow mk_* from the same clk edge that sets gntk.
  - The hold counter increments every cycle.
- Leaving OWNk normally:
  - reqk=0 → go to GUARD on the next edge.
  - Actions on that edge: gntk=0, last_owner=k, guard counter loaded with GUARD_CYCLES-1.
- Leaving OWNk on timeout:
  - Condition: HOLD_TIMEOUT≠0 and the hold counter reaches HOLD_TIMEOUT-1 while reqk is still 1.
  - Actions: go to GUARD, gntk=0, timeout_pulse=1 for one cycle, lockk=1.
  - lockk clears on the first cycle in which reqk=0.
- Timeout and request drop on the same cycle: treat as a normal release (no pulse, no lock).
- GUARD:
  - Both oe=0, so the bus floats to the pull-ups; both gnt=0.
  - The guard counter decrements; at 0 go to IDLE.
  - Requests arriving during GUARD are held pending and evaluated in IDLE.
  - Minimum gap between two grants is GUARD_CYCLES+1 cycles.
- Readback:
  - The current owner sees bus_scl_i/bus_sda_i.
  - The non-owner (and both requesters in IDLE/GUARD) see 1 on both scl_i and sda_i, i.e. an idle bus.
- Non-owner outputs are ignored entirely.
- gnt0 and gnt1 are never both 1.
- owner encodes gnt; busy = (state≠IDLE).
- Counters: hold counter is 25 bits wide, saturating; guard counter is 16 bits wide.

Optional Feature:
- Macro: SERIAL_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0[15:0], grant_cnt1[15:0] and timeout_cnt[7:0].
  - Each counter is saturating and increments on entry to OWNk, or on a timeout respectively.
  - Reset to 0 by rst_n.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- req0=1 from reset with GUARD_CYCLES=4 → gnt0=1 one cycle later, owner=01; bus_sda_o/oe track m0_sda_o/oe; m1_sda_i=1.
- req0 and req1 rise on the same cycle after reset → gnt0 first. Drop req0 → 4 guard cycles with oe=0, then gnt1. Next tie → gnt0.
- HOLD_TIMEOUT=100, req1 held high for 200 cycles → gnt1 falls after 100 cycles of grant, timeout_pulse=1 for one cycle. No re-grant until req1 goes 0 then 1 again.
- req0 dropped on exactly cycle 99 of a 100-cycle timeout → normal release, no timeout_pulse, req0 re-grantable after guard.
- rst_n asserted low mid-OWN1 → gnt1, bus oe and owner go to 0 immediately without waiting for clk. After release, with both requesting, requester 0 wins.
- With SERIAL_ARB_STATS_EN defined, 3 grants to requester 0 and 1 timeout → grant_cnt0=3, timeout_cnt=1.
